tlink_acquire_arbiter: RTL

TLINK_ACQUIRE_ARBITER -- requirements
Module: tlink_acquire_arbiter

---
 rtl/tlink_pkg.sv | 45 ++++
 rtl/tlink_rr_arbiter.sv | 34 +++
 rtl/tlink_acquire_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tlink_pkg.sv
// Shared TileLink Acquire types: header/payload structs, widths and a_type encodings.
`default_nettype none

package tlink_pkg;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
  } TLink_header_t;

  localparam int TLINK_HDR_W = $bits(TLink_header_t);

  localparam logic [2:0] ACQ_GET        = 3'd0;
  localparam logic [2:0] ACQ_GET_BLOCK  = 3'd1;
  localparam logic [2:0] ACQ_PUT        = 3'd2;
  localparam logic [2:0] ACQ_PUT_BLOCK  = 3'd3;
  localparam logic [2:0] ACQ_PUT_ATOMIC = 3'd4;

  typedef struct packed {
    logic [25:0] addr;
    logic [4:0]  client_xact_id;
    logic [31:0] data;
    logic        uncached;
    logic [2:0]  a_type;
    logic [3:0]  write_mask;
    logic [1:0]  subword_addr;
    logic [3:0]  atomic_opcode;
  } acquire_payload_t;

  localparam int ACQ_PAYLOAD_W = $bits(acquire_payload_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  // An uncached put-block is the only Acquire that opens a multi-beat burst.
  function automatic logic starts_lock(input acquire_payload_t p);
    return p.uncached && (p.a_type == ACQ_PUT_BLOCK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlink_rr_arbiter.sv
// Round-robin requester selection: first asserted request at or above rr_ptr, wrapping.
`default_nettype none

module tlink_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int IDXW = $clog2(NREQ);

  // Scan from farthest to nearest so the candidate closest to rr_ptr is written last and wins.
  always_comb begin : p_select
    int p;
    p       = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = int'(rr_ptr_i) + k;
      if (p >= NREQ) p = p - NREQ;
      if (req_i[p]) begin
        grant_o    = '0;
        grant_o[p] = 1'b1;
        idx_o      = IDXW'(p);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlink_acquire_arbiter.sv
// N:1 Acquire arbiter with a one-entry output register; TLINK_ARB_LOCK_EN holds the
// grant for LOCK_BEATS beats after an uncached put-block.
`default_nettype none

module tlink_acquire_arbiter
  import tlink_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LOCK_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*TLINK_HDR_W-1:0]   req_header,
  input  logic [NREQ*ACQ_PAYLOAD_W-1:0] req_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TLINK_HDR_W-1:0]        out_header,
  output logic [ACQ_PAYLOAD_W-1:0]      out_payload,
  output logic [$clog2(NREQ)-1:0]       out_idx,
  output logic                          locked
);

  localparam int IDXW = $clog2(NREQ);

  if ((NREQ < 2) || (NREQ > 8) || (LOCK_BEATS < 2) || (LOCK_BEATS > 16) ||
      ((LOCK_BEATS & (LOCK_BEATS - 1)) != 0)) begin : g_bad_params
    $error("tlink_acquire_arbiter: NREQ or LOCK_BEATS out of range");
  end

  arb_state_e                state_q, state_d;
  logic [IDXW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      out_valid_q;
  logic [IDXW-1:0]           out_idx_q;
  logic [TLINK_HDR_W-1:0]    out_hdr_q;
  logic [ACQ_PAYLOAD_W-1:0]  out_pay_q;

  logic [NREQ-1:0]           rr_grant, grant;
  logic [IDXW-1:0]           rr_idx, winner, ptr_inc;
  logic                      can_load, accept, out_fire, lock_start, lock_last;
  logic [TLINK_HDR_W-1:0]    win_hdr;
  logic [ACQ_PAYLOAD_W-1:0]  win_pay;

  tlink_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (rr_grant),
    .idx_o    (rr_idx)
  );

`ifdef TLINK_ARB_LOCK_EN
  localparam int BCW = $clog2(LOCK_BEATS);

  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic            in_lock;

  assign in_lock = (state_q == ST_LOCK);

  // While locked only the burst owner may be granted, and only when it is valid.
  always_comb begin
    grant  = rr_grant;
    winner = rr_idx;
    if (in_lock) begin
      grant             = '0;
      grant[lock_idx_q] = req_valid[lock_idx_q];
      winner            = lock_idx_q;
    end
  end

  assign lock_start = accept & ~in_lock & starts_lock(win_pay);
  assign lock_last  = accept & in_lock & (beat_cnt_q == BCW'(LOCK_BEATS - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    lock_idx_d = lock_idx_q;
    if (lock_start) begin
      beat_cnt_d = BCW'(1);
      lock_idx_d = winner;
    end else if (accept && in_lock) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q <= '0;
      lock_idx_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign locked = in_lock;
`else
  assign grant      = rr_grant;
  assign winner     = rr_idx;
  assign lock_start = 1'b0;
  assign lock_last  = 1'b0;
  assign locked     = 1'b0;
`endif

  assign can_load  = ~out_valid_q | out_ready;
  assign req_ready = grant & {NREQ{can_load & rstn}};
  assign accept    = |req_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign win_hdr   = req_header[int'(winner)*TLINK_HDR_W +: TLINK_HDR_W];
  assign win_pay   = req_payload[int'(winner)*ACQ_PAYLOAD_W +: ACQ_PAYLOAD_W];
  assign ptr_inc   = (winner == IDXW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = lock_start ? ST_LOCK : ST_BUSY;
      ST_BUSY: begin
        if (accept)        state_d = lock_start ? ST_LOCK : ST_BUSY;
        else if (out_fire) state_d = ST_IDLE;
      end
      ST_LOCK: if (lock_last) state_d = ST_BUSY;
      default: state_d = ST_IDLE;
    endcase
    // The pointer stays put across a burst and moves past the owner on its final beat.
    if (accept && !lock_start && ((state_q != ST_LOCK) || lock_last)) rr_ptr_d = ptr_inc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_hdr_q   <= '0;
      out_pay_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= accept | (out_valid_q & ~out_ready);
      if (accept) begin
        out_idx_q <= winner;
        out_hdr_q <= win_hdr;
        out_pay_q <= win_pay;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_header  = out_hdr_q;
  assign out_payload = out_pay_q;

endmodule

`default_nettype wire
